iir_sample_sequencer: RTL and testbench

- Sequences the mixed IIR filter datapath from one sample source.
- Per sample period: fetches one sample from the sample ROM, then time-shares a single IIR filter core between the low-pass channel and the high-pass channel, each with its own coefficient set.
- Publishes both results together with a valid pulse.
- Sits between the sample ROM, the shared filter core and the top-level low_pass/high_pass outputs.

---
 rtl/iir_sample_sequencer_if.sv | 43 ++++
 rtl/iir_sample_sequencer.sv | 172 +++++++++++++++++
 tb/tb_iir_sample_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_sample_sequencer_if.sv
// Sample ROM and shared filter core bundle for iir_sample_sequencer.
// master = sequencer side, slave = ROM/core side.
interface iir_sample_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              core_start;
  logic              core_ch;
  logic [DATA_W-1:0] core_x;
  logic [DATA_W-1:0] core_c0;
  logic [DATA_W-1:0] core_c1;
  logic [DATA_W-1:0] core_c2;
  logic              core_done;
  logic [DATA_W-1:0] core_y;

  modport master (
    output rom_addr,
    input  rom_q,
    output core_start,
    output core_ch,
    output core_x,
    output core_c0,
    output core_c1,
    output core_c2,
    input  core_done,
    input  core_y
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  core_start,
    input  core_ch,
    input  core_x,
    input  core_c0,
    input  core_c1,
    input  core_c2,
    output core_done,
    output core_y
  );
endinterface

// File: rtl/iir_sample_sequencer.sv
// Per-tick sample fetch, then LP and HP passes through one shared IIR core.
// Define IIR_SEQ_TIMEOUT_EN to add a core_done watchdog (timeout_err).
module iir_sample_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int ROM_LAT = 1,
  parameter int SAMPLE_DIV = 16,
  parameter logic [DATA_W-1:0] LP_C0 = 16'h0006,
  parameter logic [DATA_W-1:0] LP_C1 = 16'h0003,
  parameter logic [DATA_W-1:0] LP_C2 = 16'h0003,
  parameter logic [DATA_W-1:0] HP_C0 = 16'h00FC,
  parameter logic [DATA_W-1:0] HP_C1 = 16'h00FC,
  parameter logic [DATA_W-1:0] HP_C2 = 16'h80FC,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  iir_sample_sequencer_if.master bus,
  output logic [DATA_W-1:0]     low_pass,
  output logic [DATA_W-1:0]     high_pass,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  timeout_err
);

  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_chk
    $error("ROM_LAT must be 1..4");
  end
  if (SAMPLE_DIV < 4) begin : g_div_chk
    $error("SAMPLE_DIV must be >= 4");
  end
  if (TIMEOUT < 1) begin : g_to_chk
    $error("TIMEOUT must be >= 1");
  end

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RUN_LP,
    WAIT_LP,
    RUN_HP,
    WAIT_HP,
    HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LAT_W-1:0]  fcnt;
  logic [DATA_W-1:0] lp_hold;
  logic              tick;
  logic              hp_done;
  logic              drop;
  logic              expired;

  assign tick = en && (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign hp_done = (state == WAIT_HP) && bus.core_done;
  // A tick landing on the final core_done chains straight into the next fetch.
  assign drop = tick && !hp_done &&
                (state != IDLE) && (state != HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef IIR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd;
  logic            in_wait;

  assign in_wait = (state == WAIT_LP) || (state == WAIT_HP);
  assign expired = in_wait && !bus.core_done &&
                   (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (in_wait) begin
      wd <= wd + 1'b1;
    end else begin
      wd <= '0;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      fcnt           <= '0;
      lp_hold        <= '0;
      bus.rom_addr   <= '0;
      bus.core_start <= 1'b0;
      bus.core_ch    <= 1'b0;
      bus.core_x     <= '0;
      bus.core_c0    <= '0;
      bus.core_c1    <= '0;
      bus.core_c2    <= '0;
      low_pass       <= '0;
      high_pass      <= '0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      out_valid      <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (expired) timeout_err <= 1'b1;
      unique case (state)
        IDLE, HOLD: begin
          if (tick) begin
            fcnt  <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (fcnt == LAT_W'(ROM_LAT)) begin
            bus.core_x     <= bus.rom_q;
            bus.rom_addr   <= bus.rom_addr + 1'b1;
            bus.core_start <= 1'b1;
            bus.core_ch    <= 1'b0;
            bus.core_c0    <= LP_C0;
            bus.core_c1    <= LP_C1;
            bus.core_c2    <= LP_C2;
            state          <= RUN_LP;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        RUN_LP: state <= WAIT_LP;
        WAIT_LP: begin
          if (bus.core_done) begin
            lp_hold        <= bus.core_y;
            bus.core_start <= 1'b1;
            bus.core_ch    <= 1'b1;
            bus.core_c0    <= HP_C0;
            bus.core_c1    <= HP_C1;
            bus.core_c2    <= HP_C2;
            state          <= RUN_HP;
          end else if (expired) begin
            state <= HOLD;
          end
        end
        RUN_HP: state <= WAIT_HP;
        WAIT_HP: begin
          if (bus.core_done) begin
            low_pass  <= lp_hold;
            high_pass <= bus.core_y;
            out_valid <= 1'b1;
            fcnt      <= '0;
            state     <= tick ? FETCH : HOLD;
          end else if (expired) begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sample_sequencer.sv
// Directed-phase bench with random ROM contents and a reference
// model of the sample stream, core traffic and output cadence.
module tb_iir_sample_sequencer;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DIV = 16;
  localparam logic [15:0] LP0 = 16'h0006;
  localparam logic [15:0] LP1 = 16'h0003;
  localparam logic [15:0] LP2 = 16'h0003;
  localparam logic [15:0] HP0 = 16'h00FC;
  localparam logic [15:0] HP1 = 16'h00FC;
  localparam logic [15:0] HP2 = 16'h80FC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] low_pass;
  logic [DW-1:0] high_pass;
  logic          out_valid;
  logic          overrun;
  logic          timeout_err;

  iir_sample_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  iir_sample_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1),
    .SAMPLE_DIV(DIV), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .low_pass(low_pass), .high_pass(high_pass),
    .out_valid(out_valid), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [16];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int lat = 3;
  int cd = 0;
  int cyc = 0;
  int fcount = 0;
  int ocount = 0;
  int nvalid = 0;
  int nstart = 0;
  int last_ov = -1;
  int exp_gap = 0;
  int rel_cyc = 0;
  int start_cyc = 0;
  bit exp_ch = 0;
  bit busy = 0;
  bit first_ov = 1;
  bit prev_rst = 0;
  bit prev_ov = 0;
  bit prev_to = 0;
  logic [64:0] snap;
  logic [DW-1:0] snap_x;
  logic snap_ch;
  logic [DW-1:0] e_lp;
  logic [DW-1:0] e_hp;

  function automatic logic [64:0] core_in();
    return {bus.core_x, bus.core_ch, bus.core_c0,
            bus.core_c1, bus.core_c2};
  endfunction

  // core responder (y = x + ch after lat cycles) and monitors
  initial begin
    bus.core_done = 1'b0;
    bus.core_y = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.core_done = 1'b0;
      if (!rst) begin
        cd = 0; busy = 0; exp_ch = 0;
        fcount = 0; ocount = 0;
        first_ov = 1; last_ov = -1;
      end else begin
        if (!prev_rst) rel_cyc = cyc;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.core_done = 1'b1;
            bus.core_y = snap_x + {15'd0, snap_ch};
            chk("core_in_stable", core_in(), snap);
            busy = 0;
          end
        end
        if (bus.core_start) begin
          nstart++;
          chk("start_while_busy", busy, 0);
          chk("start_ch", bus.core_ch, exp_ch);
          chk("start_c0", bus.core_c0, exp_ch ? HP0 : LP0);
          chk("start_c1", bus.core_c1, exp_ch ? HP1 : LP1);
          chk("start_c2", bus.core_c2, exp_ch ? HP2 : LP2);
          if (!exp_ch) begin
            chk("lp_x", bus.core_x, rom[fcount % 16]);
            chk("rom_addr", bus.rom_addr, (fcount + 1) % 16);
            fcount++;
          end else begin
            chk("hp_x", bus.core_x, rom[(fcount + 15) % 16]);
          end
          snap = core_in();
          snap_x = bus.core_x;
          snap_ch = bus.core_ch;
          exp_ch = ~exp_ch;
          busy = 1;
          start_cyc = cyc;
          if (lat > 0) cd = lat;
        end
        if (out_valid) begin
          e_lp = rom[ocount % 16];
          e_hp = rom[ocount % 16] + 16'd1;
          chk("low_pass", low_pass, e_lp);
          chk("high_pass", high_pass, e_hp);
          chk("valid_pulse", prev_ov, 0);
          if (first_ov) chk("first_valid_cyc", cyc - rel_cyc, 26);
          if (exp_gap != 0 && last_ov >= 0)
            chk("valid_gap", cyc - last_ov, exp_gap);
          first_ov = 0;
          last_ov = cyc;
          ocount++;
          nvalid++;
        end
`ifdef IIR_SEQ_TIMEOUT_EN
        if (timeout_err && !prev_to) begin
          chk("timeout_cyc", cyc - start_cyc, 33);
          busy = 0; exp_ch = 0; cd = 0;
          ocount++;
        end
`endif
      end
      prev_rst = rst;
      prev_ov = out_valid;
      prev_to = timeout_err;
    end
  end

  task automatic wait_valid(input int target, input int budget,
                            input string tag);
    int n = 0;
    while (nvalid < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, nvalid, target);
  endtask

  task automatic wait_busy(input bit lp_only, input string tag);
    int n = 0;
    while (!(busy && (!lp_only || exp_ch)) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(tag, busy, 1);
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_rom_addr"}, bus.rom_addr, 0);
    chk({ph, "_core_start"}, bus.core_start, 0);
    chk({ph, "_core_ch"}, bus.core_ch, 0);
    chk({ph, "_core_x"}, bus.core_x, 0);
    chk({ph, "_core_c"}, {bus.core_c0, bus.core_c1, bus.core_c2}, 0);
    chk({ph, "_low_pass"}, low_pass, 0);
    chk({ph, "_high_pass"}, high_pass, 0);
    chk({ph, "_out_valid"}, out_valid, 0);
    chk({ph, "_overrun"}, overrun, 0);
    chk({ph, "_timeout_err"}, timeout_err, 0);
  endtask

  int n0;
  int s0;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
    rom[15] = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");

    en = 1;
    @(posedge clk);
    #2 rst = 1;
    wait_valid(1, 60, "first_sample");
    chk("addr_after_first", bus.rom_addr, 1);

    exp_gap = 16;
    wait_valid(40, 40 * 16 + 60, "forty_samples");
    chk("overrun_lat3", overrun, 0);

    lat = 6;
    last_ov = -1;
    wait_valid(nvalid + 8, 8 * 16 + 60, "lat6_samples");
    chk("overrun_tick_on_done", overrun, 0);

    lat = 20;
    exp_gap = 0;
    wait_valid(nvalid + 3, 3 * 48 + 80, "lat20_samples");
    chk("overrun_sticky", overrun, 1);

    wait_busy(1, "reach_wait_lp");
    repeat (4) @(posedge clk);
    chk("still_wait_lp", busy && exp_ch, 1);
    #3 rst = 0;
    #1 check_zero("async_reset");
    lat = 3;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    exp_gap = 16;
    wait_valid(nvalid + 17, 17 * 16 + 60, "wrap_samples");
    chk("addr_wrapped", bus.rom_addr, 1);
    chk("overrun_after_reset", overrun, 0);

    exp_gap = 0;
    wait_busy(0, "busy_before_en_low");
    en = 0;
    wait_valid(nvalid + 1, 60, "finish_on_en_low");
    n0 = nvalid;
    s0 = nstart;
    repeat (80) @(posedge clk);
    chk("hold_no_valid", nvalid, n0);
    chk("hold_no_start", nstart, s0);
    en = 1;

`ifdef IIR_SEQ_TIMEOUT_EN
    wait_valid(nvalid + 1, 60, "resume_sample");
    lat = 0;
    n0 = nvalid;
    for (int i = 0; i < 100 && !timeout_err; i++) @(posedge clk);
    chk("timeout_err_set", timeout_err, 1);
    chk("no_valid_on_timeout", nvalid, n0);
    lat = 3;
    wait_valid(nvalid + 1, 60, "after_timeout");
    chk("timeout_sticky", timeout_err, 1);
`else
    wait_valid(nvalid + 1, 60, "resume_sample");
    chk("timeout_tied_low", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
